branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  ID-stage dynamic branch predictor: a 2-bit saturating-counter branch history table (BHT).
//  Decodes BEQ/BNE in ID, looks up the BHT and computes the branch target. Drives the
//  branch_prediction_in / branch_target_addr_in inputs of the ID/EX latch.
//  EX resolves each branch and returns the outcome here to train the BHT.
//  Also keeps saturating resolved-branch and misprediction counters for debug/performance.
// PARAMETERS
//  INDEX_BITS    6      BHT index width; entries = 2**INDEX_BITS
//  COUNTER_INIT  2'b01  reset value of every BHT entry (weakly not-taken)
//  STAT_WIDTH    16     width of each statistics counter
// PORTS
//  clk                     in   1           clock, rising edge
//  reset                   in   1           asynchronous, active-high
//  id_pc_in                in   32          address of the instruction in ID
//  id_pc_plus4_in          in   32          id_pc_in + 4
//  id_opcode_in            in   6           opcode of the instruction in ID
//  id_sign_ext_imm_in      in   32          sign-extended immediate of the instruction in ID
//  ex_branch_valid_in      in   1           EX holds a resolved conditional branch this cycle
//  ex_pc_in                in   32          address of that branch
//  ex_taken_in             in   1           actual outcome (1 = taken)
//  ex_predicted_in         in   1           prediction carried down the pipe for that branch
//  branch_prediction_out   out  1           predict taken (to ID/EX latch)
//  branch_target_addr_out  out  32          predicted target (to ID/EX latch)
//  is_branch_out           out  1           instruction in ID is BEQ/BNE
//  stat_branches_out       out  STAT_WIDTH  number of resolved branches
//  stat_mispredicts_out    out  STAT_WIDTH  number of mispredicted branches
// BEHAVIOUR
//  Reset (async, on assertion): all BHT entries = COUNTER_INIT; both stat counters = 0.
//    The ID-side outputs are combinational; they follow the inputs and the reset table.
//  Decode: is_branch_out = (opcode == OP_BEQ 6'b000100) | (opcode == OP_BNE 6'b000101).
//  Lookup (combinational, 0-cycle latency):
//    rd_idx = id_pc_in[INDEX_BITS+1:2]
//    branch_prediction_out = is_branch_out & bht[rd_idx][1]; 0 for non-branches
//    branch_target_addr_out = id_pc_plus4_in + {id_sign_ext_imm_in[29:0], 2'b00}, 32-bit wrap
//    The target is driven for every opcode; consumers qualify it with the prediction.
//  Update (registered, on posedge clk when ex_branch_valid_in = 1):
//    wr_idx = ex_pc_in[INDEX_BITS+1:2]
//    taken: the entry increments and saturates at 2'b11.
//    not taken: the entry decrements and saturates at 2'b00.
//    Counter states: 00 strong-NT -> 01 weak-NT -> 10 weak-T -> 11 strong-T.
//    Updates are independent of any ID stall or flush. A flush never cancels a resolved branch.
//  Same-cycle read/write of the same index: the lookup returns the OLD entry (no bypass).
//    The new value is visible from the next cycle.
//  Aliasing: PCs with equal index bits share an entry. There is no tag check, by design.
//  Stats (posedge, when ex_branch_valid_in = 1):
//    stat_branches_out += 1
//    stat_mispredicts_out += 1 if ex_taken_in != ex_predicted_in
//    Both counters saturate at all-ones; they never wrap.
//  Reset mid-operation: the table and stats clear at once; an update in flight that cycle is lost.
//  No X propagation: an unused ex_* input while valid = 0 must not change any state.
// STRUCTURE
//  mips_pkg.vh: OP_BEQ, OP_BNE, BHT_STRONG_NT/WEAK_NT/WEAK_T/STRONG_T, DATA_WIDTH.
//  Sub-module sat_counter2 (2-bit saturating inc/dec, combinational next-state).
//    Instantiate it once, on the write path.
//  BHT is a reg array [0:2**INDEX_BITS-1][1:0] with async reset. No RAM inference required.
// TESTING
//  1 Reset, then lookup BEQ at pc 0x40 -> prediction 0 (01); target = pc+4 + imm<<2.
//    imm = 0xFFFFFFFF gives 0x40.
//  2 Resolve pc 0x40 taken twice -> entry 11, prediction 1.
//    A third taken keeps 11; stat_branches = 3, mispredicts = (per ex_predicted_in).
//  3 From 11, resolve not-taken x4 -> 10,01,00,00; prediction flips to 0 after the 2nd.
//  4 Lookup and update of pc 0x80 in the same cycle -> old value this cycle, new value next.
//  5 Alias check: pc 0x40 and 0x140 (INDEX_BITS=6) share an entry; training one moves the other.
//    ADD opcode -> prediction 0 regardless of table contents.
//  6 Preload stats near all-ones (force or long run) -> saturate.
//    Assert reset mid-update -> all outputs and table return to reset values asynchronously.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared constants and helpers for the ID-stage branch predictor:
// opcodes, BHT counter encodings and the target-address computation.
package branch_predictor_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    typedef enum logic [1:0] {
        BHT_STRONG_NT = 2'b00,
        BHT_WEAK_NT   = 2'b01,
        BHT_WEAK_T    = 2'b10,
        BHT_STRONG_T  = 2'b11
    } bht_state_e;

    function automatic logic is_cond_branch(input logic [5:0] opcode);
        return (opcode == OP_BEQ) || (opcode == OP_BNE);
    endfunction

    // Word-aligned PC-relative target; the top two immediate bits fall off the shift.
    function automatic logic [DATA_WIDTH-1:0] branch_target(
        input logic [DATA_WIDTH-1:0] pc_plus4,
        input logic [DATA_WIDTH-1:0] sign_ext_imm
    );
        return pc_plus4 + {sign_ext_imm[DATA_WIDTH-3:0], 2'b00};
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating up/down counter, next-state only; the caller owns the storage.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cnt_i,
    input  logic       taken_i,
    output logic [1:0] cnt_o
);

    // Step one state toward taken or not-taken, holding at the ends.
    always_comb begin
        cnt_o = cnt_i;
        case (cnt_i)
            BHT_STRONG_NT: cnt_o = taken_i ? BHT_WEAK_NT   : BHT_STRONG_NT;
            BHT_WEAK_NT:   cnt_o = taken_i ? BHT_WEAK_T    : BHT_STRONG_NT;
            BHT_WEAK_T:    cnt_o = taken_i ? BHT_STRONG_T  : BHT_WEAK_NT;
            BHT_STRONG_T:  cnt_o = taken_i ? BHT_STRONG_T  : BHT_WEAK_T;
            default:       cnt_o = cnt_i;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// ID-stage 2-bit BHT branch predictor with combinational lookup, EX-driven training
// and saturating resolved-branch / misprediction statistics.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int         INDEX_BITS   = 6,
    parameter logic [1:0] COUNTER_INIT = 2'b01,
    parameter int         STAT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           id_pc_in,
    input  logic [31:0]           id_pc_plus4_in,
    input  logic [5:0]            id_opcode_in,
    input  logic [31:0]           id_sign_ext_imm_in,
    input  logic                  ex_branch_valid_in,
    input  logic [31:0]           ex_pc_in,
    input  logic                  ex_taken_in,
    input  logic                  ex_predicted_in,
    output logic                  branch_prediction_out,
    output logic [31:0]           branch_target_addr_out,
    output logic                  is_branch_out,
    output logic [STAT_WIDTH-1:0] stat_branches_out,
    output logic [STAT_WIDTH-1:0] stat_mispredicts_out
);

    localparam int ENTRIES = 2 ** INDEX_BITS;

    logic [1:0]            bht_q [0:ENTRIES-1];
    logic [INDEX_BITS-1:0] rd_idx_s;
    logic [INDEX_BITS-1:0] wr_idx_s;
    logic [1:0]            rd_entry_s;
    logic [1:0]            wr_entry_s;
    logic [1:0]            wr_next_s;
    logic [STAT_WIDTH-1:0] stat_br_q;
    logic [STAT_WIDTH-1:0] stat_br_d;
    logic [STAT_WIDTH-1:0] stat_mp_q;
    logic [STAT_WIDTH-1:0] stat_mp_d;
    logic                  unused_bits_s;

    assign rd_idx_s   = id_pc_in[INDEX_BITS+1:2];
    assign wr_idx_s   = ex_pc_in[INDEX_BITS+1:2];
    assign rd_entry_s = bht_q[rd_idx_s];
    assign wr_entry_s = bht_q[wr_idx_s];

    // PC bits outside the index and the shifted-out immediate bits carry no information here.
    assign unused_bits_s = ^{id_pc_in[31:INDEX_BITS+2], id_pc_in[1:0],
                             ex_pc_in[31:INDEX_BITS+2], ex_pc_in[1:0],
                             id_sign_ext_imm_in[31:30]};

    sat_counter2 u_wr_counter (
        .cnt_i   (wr_entry_s),
        .taken_i (ex_taken_in),
        .cnt_o   (wr_next_s)
    );

    // Lookup reads the stored entry, so a same-cycle write is seen only next cycle.
    always_comb begin
        is_branch_out          = is_cond_branch(id_opcode_in);
        branch_prediction_out  = is_branch_out & rd_entry_s[1];
        branch_target_addr_out = branch_target(id_pc_plus4_in, id_sign_ext_imm_in);
    end

    // Saturating statistics next-state; only a valid resolution may move them.
    always_comb begin
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (ex_branch_valid_in) begin
            if (stat_br_q != {STAT_WIDTH{1'b1}}) begin
                stat_br_d = stat_br_q + {{(STAT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                stat_br_d = stat_br_q;
            end
            if ((ex_taken_in != ex_predicted_in) && (stat_mp_q != {STAT_WIDTH{1'b1}})) begin
                stat_mp_d = stat_mp_q + {{(STAT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                stat_mp_d = stat_mp_q;
            end
        end else begin
            stat_br_d = stat_br_q;
            stat_mp_d = stat_mp_q;
        end
    end

    // BHT storage: cleared asynchronously, trained by each resolved branch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht_q[i] <= COUNTER_INIT;
            end
        end else if (ex_branch_valid_in) begin
            bht_q[wr_idx_s] <= wr_next_s;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_br_q <= {STAT_WIDTH{1'b0}};
            stat_mp_q <= {STAT_WIDTH{1'b0}};
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign stat_branches_out    = stat_br_q;
    assign stat_mispredicts_out = stat_mp_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor (stats narrowed to 4 bits so saturation is reachable).
module tb_branch_predictor;

    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   id_pc_in, id_pc_plus4_in, id_sign_ext_imm_in, ex_pc_in;
    logic [5:0]    id_opcode_in;
    logic          ex_branch_valid_in, ex_taken_in, ex_predicted_in;
    logic          branch_prediction_out, is_branch_out;
    logic [31:0]   branch_target_addr_out;
    logic [SW-1:0] stat_branches_out, stat_mispredicts_out;

    typedef struct packed {
        logic        pred;
        logic        isb;
        logic [31:0] tgt;
    } exp_t;

    exp_t       sb_q[$];
    logic [1:0] mdl [0:63];
    int         mdl_br = 0;
    int         mdl_mp = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    branch_predictor #(.INDEX_BITS(6), .COUNTER_INIT(2'b01), .STAT_WIDTH(SW)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .id_pc_in               (id_pc_in),
        .id_pc_plus4_in         (id_pc_plus4_in),
        .id_opcode_in           (id_opcode_in),
        .id_sign_ext_imm_in     (id_sign_ext_imm_in),
        .ex_branch_valid_in     (ex_branch_valid_in),
        .ex_pc_in               (ex_pc_in),
        .ex_taken_in            (ex_taken_in),
        .ex_predicted_in        (ex_predicted_in),
        .branch_prediction_out  (branch_prediction_out),
        .branch_target_addr_out (branch_target_addr_out),
        .is_branch_out          (is_branch_out),
        .stat_branches_out      (stat_branches_out),
        .stat_mispredicts_out   (stat_mispredicts_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mdl[i] = 2'b01;
        mdl_br = 0;
        mdl_mp = 0;
    endtask

    // Drive an ID instruction now and queue what the predictor should say about it.
    task automatic id_drive(input logic [31:0] pc, input logic [5:0] op, input logic [31:0] imm);
        exp_t       e;
        logic [5:0] idx;
        id_pc_in           = pc;
        id_pc_plus4_in     = pc + 32'd4;
        id_opcode_in       = op;
        id_sign_ext_imm_in = imm;
        idx    = pc[7:2];
        e.isb  = (op == 6'b000100) || (op == 6'b000101);
        e.pred = e.isb & mdl[idx][1];
        e.tgt  = pc + 32'd4 + (imm << 2);
        sb_q.push_back(e);
    endtask

    task automatic id_check(input string tag);
        exp_t e;
        #2;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_isb"},  {31'd0, is_branch_out},         {31'd0, e.isb});
            chk({tag, "_pred"}, {31'd0, branch_prediction_out}, {31'd0, e.pred});
            chk({tag, "_tgt"},  branch_target_addr_out,         e.tgt);
        end
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic [5:0] op,
                          input logic [31:0] imm);
        @(negedge clk);
        id_drive(pc, op, imm);
        id_check(tag);
    endtask

    task automatic model_update(input logic [31:0] pc, input logic taken, input logic predicted);
        logic [5:0] idx;
        idx = pc[7:2];
        if (taken && mdl[idx] != 2'b11) mdl[idx] = mdl[idx] + 2'd1;
        else if (!taken && mdl[idx] != 2'b00) mdl[idx] = mdl[idx] - 2'd1;
        if (mdl_br < 15) mdl_br++;
        if (taken != predicted && mdl_mp < 15) mdl_mp++;
    endtask

    task automatic ex_idle();
        ex_branch_valid_in = 1'b0;
        ex_pc_in           = $urandom;
        ex_taken_in        = 1'($urandom_range(0, 1));
        ex_predicted_in    = 1'($urandom_range(0, 1));
    endtask

    task automatic resolve(input logic [31:0] pc, input logic taken, input logic predicted);
        @(negedge clk);
        ex_branch_valid_in = 1'b1;
        ex_pc_in           = pc;
        ex_taken_in        = taken;
        ex_predicted_in    = predicted;
        @(posedge clk);
        model_update(pc, taken, predicted);
        @(negedge clk);
        ex_idle();
    endtask

    task automatic chk_stats(input string tag);
        chk({tag, "_br"}, {28'd0, stat_branches_out},    mdl_br);
        chk({tag, "_mp"}, {28'd0, stat_mispredicts_out}, mdl_mp);
    endtask

    initial begin
        reset = 1'b1;
        ex_idle();
        id_pc_in = 32'd0; id_pc_plus4_in = 32'd4; id_opcode_in = 6'd0; id_sign_ext_imm_in = 32'd0;
        model_reset();
        #1;
        chk("rst_br", {28'd0, stat_branches_out}, 32'd0);
        chk("rst_mp", {28'd0, stat_mispredicts_out}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // 1: reset lookup and target arithmetic
        lookup("t1_beq40", 32'h40, 6'b000100, 32'hFFFF_FFFF);
        chk("t1_tgt_const", branch_target_addr_out, 32'h40);
        chk("t1_pred_const", {31'd0, branch_prediction_out}, 32'd0);
        lookup("t1_fwd", 32'h40, 6'b000101, 32'h10);
        chk("t1_fwd_const", branch_target_addr_out, 32'h84);
        lookup("t1_wrap", 32'hFFFF_FFF0, 6'b000100, 32'h4);
        chk("t1_wrap_const", branch_target_addr_out, 32'h4);

        // 2: train taken to saturation
        resolve(32'h40, 1'b1, 1'b0);
        lookup("t2_once", 32'h40, 6'b000100, 32'h0);
        resolve(32'h40, 1'b1, 1'b0);
        lookup("t2_twice", 32'h40, 6'b000100, 32'h0);
        chk("t2_pred_const", {31'd0, branch_prediction_out}, 32'd1);
        resolve(32'h40, 1'b1, 1'b1);
        lookup("t2_sat", 32'h40, 6'b000100, 32'h0);
        chk_stats("t2_stats");
        chk("t2_br_const", {28'd0, stat_branches_out}, 32'd3);
        chk("t2_mp_const", {28'd0, stat_mispredicts_out}, 32'd2);

        // 3: four not-taken from strong-taken
        resolve(32'h40, 1'b0, 1'b1);
        lookup("t3_nt1", 32'h40, 6'b000100, 32'h0);
        chk("t3_nt1_const", {31'd0, branch_prediction_out}, 32'd1);
        resolve(32'h40, 1'b0, 1'b1);
        lookup("t3_nt2", 32'h40, 6'b000100, 32'h0);
        chk("t3_nt2_const", {31'd0, branch_prediction_out}, 32'd0);
        resolve(32'h40, 1'b0, 1'b0);
        resolve(32'h40, 1'b0, 1'b0);
        resolve(32'h140, 1'b1, 1'b0);
        lookup("t3_floor", 32'h40, 6'b000100, 32'h0);
        chk("t3_floor_const", {31'd0, branch_prediction_out}, 32'd0);
        chk_stats("t3_stats");

        // 4: same-cycle lookup and update of 0x80
        @(negedge clk);
        ex_branch_valid_in = 1'b1; ex_pc_in = 32'h80; ex_taken_in = 1'b1; ex_predicted_in = 1'b0;
        id_drive(32'h80, 6'b000100, 32'h8);
        id_check("t4_old");
        chk("t4_old_const", {31'd0, branch_prediction_out}, 32'd0);
        @(posedge clk);
        model_update(32'h80, 1'b1, 1'b0);
        @(negedge clk);
        ex_idle();
        id_check_new: begin
            id_drive(32'h80, 6'b000100, 32'h8);
            id_check("t4_new");
        end
        chk("t4_new_const", {31'd0, branch_prediction_out}, 32'd1);

        // 5: aliasing and non-branch opcodes
        resolve(32'h140, 1'b1, 1'b0);
        lookup("t5_alias", 32'h40, 6'b000100, 32'h0);
        chk("t5_alias_const", {31'd0, branch_prediction_out}, 32'd1);
        lookup("t5_add", 32'h40, 6'b000000, 32'h0);
        chk("t5_add_const", {31'd0, branch_prediction_out}, 32'd0);
        lookup("t5_lw", 32'h80, 6'b100011, 32'h3);

        // 6: stats saturation, then reset during an update
        for (int i = 0; i < 12; i++) resolve(32'h200 + 32'(i * 4), 1'(i % 2), 1'((i + 1) % 2));
        chk_stats("t6_sat");
        chk("t6_br_const", {28'd0, stat_branches_out}, 32'd15);
        chk("t6_mp_const", {28'd0, stat_mispredicts_out}, 32'd15);
        @(negedge clk);
        ex_branch_valid_in = 1'b1; ex_pc_in = 32'h40; ex_taken_in = 1'b1; ex_predicted_in = 1'b0;
        #1;
        reset = 1'b1;
        model_reset();
        id_drive(32'h40, 6'b000100, 32'h0);
        id_check("t6_async");
        chk_stats("t6_async_stats");
        @(posedge clk);
        @(negedge clk);
        ex_idle();
        reset = 1'b0;
        lookup("t6_lost", 32'h40, 6'b000100, 32'h0);
        chk("t6_lost_const", {31'd0, branch_prediction_out}, 32'd0);
        lookup("t6_clr80", 32'h80, 6'b000101, 32'h0);
        chk_stats("t6_post_stats");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
